audio_level_meter: RTL and testbench

//  Converts the raw microphone sample stream into a 0-9 loudness level for the seven-segment driver's audio digit.
//  - Sits between the mic capture block and the display driver.
//  - Tracks peak amplitude over a fixed window of samples.
//  - Quantises the peak sequentially against evenly spaced thresholds.
//  - Applies a one-step-per-window decay so the digit falls smoothly.

---
 rtl/audio_level_meter.sv | 113 +++++++++++
 tb/tb_audio_level_meter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_level_meter.sv
// Peak-hold loudness meter: per-window peak amplitude of the mic stream,
// quantised to 0..9 with an optional one-step-per-window decay.
module audio_level_meter #(
    parameter int SAMPLE_BITS = 12,
    parameter int MID         = 2048,
    parameter int WINDOW      = 4000,
    parameter int STEP        = 205,
    parameter int DECAY       = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   sample_en,
    input  logic [SAMPLE_BITS-1:0] mic_in,
    output logic [3:0]             audio_level,
    output logic                   level_update,
    output logic [SAMPLE_BITS-1:0] window_peak
);

    typedef enum logic [1:0] {
        ACCUM,
        QUANT,
        APPLY
    } state_t;

    localparam logic [SAMPLE_BITS-1:0] MID_C    = SAMPLE_BITS'(MID);
    localparam logic [SAMPLE_BITS-1:0] STEP_C   = SAMPLE_BITS'(STEP);
    localparam logic [SAMPLE_BITS-1:0] AMP_MAX  = {1'b0, {(SAMPLE_BITS-1){1'b1}}};
    localparam logic [15:0]            CNT_LAST = 16'(WINDOW - 1);
    localparam bit                     DECAY_ON = (DECAY != 0);

    state_t                 r_state;
    state_t                 w_nextState;
    logic [15:0]            r_cnt;
    logic [SAMPLE_BITS-1:0] r_acc;
    logic [SAMPLE_BITS-1:0] r_thr;
    logic [3:0]             r_k;
    logic [3:0]             r_raw;

    logic [SAMPLE_BITS-1:0] w_amp;
    logic [SAMPLE_BITS-1:0] w_ampSat;
    logic [SAMPLE_BITS-1:0] w_peakNew;
    logic                   w_windowEnd;

    // Below-midpoint excursions can reach MID, one more than the positive side allows.
    assign w_amp       = (mic_in >= MID_C) ? (mic_in - MID_C) : (MID_C - mic_in);
    assign w_ampSat    = (w_amp > AMP_MAX) ? AMP_MAX : w_amp;
    assign w_peakNew   = (w_ampSat > r_acc) ? w_ampSat : r_acc;
    assign w_windowEnd = sample_en && (r_cnt == CNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ACCUM:   if (w_windowEnd) w_nextState = QUANT;
            QUANT:   if (r_k == 4'd9) w_nextState = APPLY;
            APPLY:   w_nextState = ACCUM;
            default: w_nextState = ACCUM;
        endcase
    end

    // Accumulation keeps running through QUANT/APPLY so no sample is lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_acc        <= '0;
            r_thr        <= '0;
            r_k          <= '0;
            r_raw        <= '0;
            window_peak  <= '0;
            audio_level  <= '0;
            level_update <= 1'b0;
        end else begin
            level_update <= 1'b0;

            if (sample_en) begin
                if (w_windowEnd) begin
                    window_peak <= w_peakNew;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc <= w_peakNew;
                    r_cnt <= r_cnt + 16'd1;
                end
            end

            if (w_windowEnd) begin
                r_k   <= 4'd1;
                r_thr <= STEP_C;
                r_raw <= '0;
            end else if (r_state == QUANT) begin
                if (window_peak >= r_thr) r_raw <= r_k;
                r_k <= r_k + 4'd1;
                // Holding the last threshold keeps it within 9*STEP.
                if (r_k != 4'd9) r_thr <= r_thr + STEP_C;
            end else if (r_state == APPLY) begin
                if (!DECAY_ON || (r_raw >= audio_level)) begin
                    audio_level <= r_raw;
                end else begin
                    audio_level <= audio_level - 4'd1;
                end
                level_update <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_audio_level_meter.sv
// Self-checking bench for audio_level_meter: table-driven windows, random
// windows against a plain-arithmetic model, continuous streaming and mid-QUANT reset.
module tb_audio_level_meter;

    localparam int SB    = 12;
    localparam int MIDV  = 2048;
    localparam int WIN   = 16;
    localparam int STEPV = 205;

    logic          clock = 1'b0;
    logic          reset;
    logic          sample_en;
    logic [SB-1:0] mic_in;
    logic [3:0]    audio_level;
    logic          level_update;
    logic [SB-1:0] window_peak;
    logic [3:0]    audio_level0;
    logic          level_update0;
    logic [SB-1:0] window_peak0;

    int assertCount = 0;
    int failCount   = 0;
    int modelLevel  = 0;

    typedef struct {
        int spikeSample;
        int spikePos;
        int expPeak;
        int expLevel;
    } vec_t;

    vec_t vecs[10];

    audio_level_meter #(
        .SAMPLE_BITS(SB), .MID(MIDV), .WINDOW(WIN), .STEP(STEPV), .DECAY(1)
    ) dut (
        .clock(clock), .reset(reset), .sample_en(sample_en), .mic_in(mic_in),
        .audio_level(audio_level), .level_update(level_update), .window_peak(window_peak)
    );

    // A no-decay instance shares the stimulus so its level shows the raw quantisation.
    audio_level_meter #(
        .SAMPLE_BITS(SB), .MID(MIDV), .WINDOW(WIN), .STEP(STEPV), .DECAY(0)
    ) dut0 (
        .clock(clock), .reset(reset), .sample_en(sample_en), .mic_in(mic_in),
        .audio_level(audio_level0), .level_update(level_update0), .window_peak(window_peak0)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int ampOf(input int s);
        int a;
        a = (s >= MIDV) ? s - MIDV : MIDV - s;
        return (a > 2047) ? 2047 : a;
    endfunction

    function automatic int rawOf(input int peak);
        return (peak / STEPV > 9) ? 9 : peak / STEPV;
    endfunction

    function automatic int decayOf(input int lvl, input int raw);
        return (raw >= lvl) ? raw : lvl - 1;
    endfunction

    task automatic applyStimulus(input int s, input int gap);
        sample_en = 1'b1;
        mic_in    = SB'(s);
        @(posedge clock);
        #1;
        sample_en = 1'b0;
        repeat (gap) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Waits out the quantise/apply latency after the window-closing sample.
    task automatic finishWindow(input string tag, input int expPeak, input int expLevel);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clock);
            #1;
            n++;
            if (level_update) seen = 1'b1;
        end
        checkOutput({tag, " latency"}, seen ? n : -1, 10);
        checkOutput({tag, " window_peak"}, int'(window_peak), expPeak);
        checkOutput({tag, " audio_level"}, int'(audio_level), expLevel);
        checkOutput({tag, " raw level (no decay)"}, int'(audio_level0), rawOf(expPeak));
        @(posedge clock);
        #1;
        checkOutput({tag, " pulse width"}, int'(level_update), 0);
    endtask

    task automatic spikeWindow(input int spike, input int pos);
        for (int i = 0; i < WIN; i++) begin
            applyStimulus((i == pos) ? spike : MIDV, 0);
        end
    endtask

    initial begin
        int samples[WIN];
        int peak;
        int span;
        int pulses;
        int firstPulse;
        int lastPulse;
        int spacingBad;

        vecs[0] = '{2252, 15,  204, 0};
        vecs[1] = '{2253,  0,  205, 1};
        vecs[2] = '{3000, 15,  952, 4};
        vecs[3] = '{3892,  7, 1844, 8};
        vecs[4] = '{3893, 15, 1845, 9};
        vecs[5] = '{2048,  0,    0, 8};
        vecs[6] = '{2048,  0,    0, 7};
        vecs[7] = '{   0, 15, 2047, 9};
        vecs[8] = '{ 204,  3, 1844, 8};
        vecs[9] = '{4095, 15, 2047, 9};

        reset     = 1'b1;
        sample_en = 1'b0;
        mic_in    = SB'(MIDV);
        repeat (5) @(posedge clock);
        #1;
        checkOutput("reset audio_level", int'(audio_level), 0);
        checkOutput("reset level_update", int'(level_update), 0);
        checkOutput("reset window_peak", int'(window_peak), 0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        spikeWindow(MIDV, 0);
        finishWindow("silent window", 0, 0);

        for (int v = 0; v < 10; v++) begin
            spikeWindow(vecs[v].spikeSample, vecs[v].spikePos);
            finishWindow($sformatf("vector %0d", v), vecs[v].expPeak, vecs[v].expLevel);
        end
        modelLevel = vecs[9].expLevel;

        for (int w = 0; w < 8; w++) begin
            span = $urandom_range(0, 2047);
            peak = 0;
            for (int i = 0; i < WIN; i++) begin
                if ($urandom_range(0, 1) == 1) samples[i] = MIDV + $urandom_range(0, span);
                else                           samples[i] = MIDV - $urandom_range(0, span);
                if (samples[i] > 4095) samples[i] = 4095;
                if (ampOf(samples[i]) > peak) peak = ampOf(samples[i]);
            end
            for (int i = 0; i < WIN; i++) begin
                applyStimulus(samples[i], (i == WIN - 1) ? 0 : $urandom_range(0, 2));
            end
            modelLevel = decayOf(modelLevel, rawOf(peak));
            finishWindow($sformatf("random window %0d", w), peak, modelLevel);
        end

        pulses     = 0;
        firstPulse = -1;
        lastPulse  = -1;
        spacingBad = 0;
        mic_in     = SB'(MIDV);
        for (int e = 1; e <= 80; e++) begin
            sample_en = (e <= 64);
            @(posedge clock);
            #1;
            if (level_update) begin
                if (firstPulse < 0) firstPulse = e;
                else if (e - lastPulse != 16) spacingBad++;
                lastPulse = e;
                pulses++;
            end
        end
        sample_en = 1'b0;
        for (int i = 0; i < 4; i++) modelLevel = decayOf(modelLevel, 0);
        checkOutput("stream pulse count", pulses, 4);
        checkOutput("stream first pulse edge", firstPulse, 26);
        checkOutput("stream pulse spacing errors", spacingBad, 0);
        checkOutput("stream audio_level", int'(audio_level), modelLevel);

        spikeWindow(0, 15);
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("mid-quant reset audio_level", int'(audio_level), 0);
        checkOutput("mid-quant reset window_peak", int'(window_peak), 0);
        checkOutput("mid-quant reset level_update", int'(level_update), 0);
        @(posedge clock);
        #1;
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clock);
            #1;
            if (level_update) pulses++;
        end
        checkOutput("aborted window pulses", pulses, 0);
        checkOutput("aborted window audio_level", int'(audio_level), 0);
        modelLevel = 0;

        spikeWindow(3000, 15);
        finishWindow("post-reset window", 952, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
